// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage feeding a single-cycle ALU, with EX and result-stage tags.
// Define ALU_ISSUE_FWD_EN to forward Result instead of stalling on result-stage dependencies.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] Result,
  output logic [2:0]      ALU_ctrl,
  output logic [2:0]      Funct3,
  output logic            Funct7_5,
  output logic            Sub,
  output logic [XLEN-1:0] Rs1,
  output logic [XLEN-1:0] Rs2,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic            res_valid_r;
  logic            res_we_r;
  logic [4:0]      res_rd_r;

  logic            legal_s;
  logic            use_rs1_s;
  logic            use_rs2_s;
  logic            we_s;
  logic            sub_s;
  logic            f75_s;
  logic [2:0]      ctrl_s;
  logic [XLEN-1:0] src1_s;
  logic [XLEN-1:0] src2_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_s;
  logic            dep1_s;
  logic            dep2_s;
  logic            hazard_s;
  logic            accept_s;

  function automatic logic [2:0] alu_ctrl_of(input logic [2:0] f3);
    logic [2:0] ctrl;
    case (f3)
      3'b000:                 ctrl = 3'b000;
      3'b010, 3'b011:         ctrl = 3'b001;
      3'b100, 3'b110, 3'b111: ctrl = 3'b010;
      3'b001, 3'b101:         ctrl = 3'b011;
      default:                ctrl = 3'b000;
    endcase
    return ctrl;
  endfunction

  // x0 never matches: it is never written, so it can neither stall nor forward
  function automatic logic tag_hit(input logic [4:0] src, input logic v, input logic we,
                                   input logic [4:0] rd);
    return (src != 5'd0) && v && we && (src == rd);
  endfunction

`ifdef ALU_ISSUE_FWD_EN
  assign src1_s = tag_hit(rs1_addr, res_valid_r, res_we_r, res_rd_r) ? Result : rs1_data;
  assign src2_s = tag_hit(rs2_addr, res_valid_r, res_we_r, res_rd_r) ? Result : rs2_data;
`else
  logic unused_result_s;
  assign unused_result_s = ^Result;
  assign src1_s = rs1_data;
  assign src2_s = rs2_data;
`endif

  // Opcode decode: ALU operation, operand selection and source usage
  always_comb begin
    legal_s   = 1'b1;
    use_rs1_s = 1'b1;
    use_rs2_s = 1'b0;
    ctrl_s    = 3'b000;
    f75_s     = 1'b0;
    sub_s     = 1'b0;
    opa_s     = src1_s;
    opb_s     = imm;
    case (opcode)
      OPC_OP: begin
        use_rs2_s = 1'b1;
        opb_s     = src2_s;
        ctrl_s    = alu_ctrl_of(funct3);
        f75_s     = funct7_5;
        sub_s     = (funct3 == 3'b000) && funct7_5;
      end
      OPC_IMM: begin
        ctrl_s = alu_ctrl_of(funct3);
        f75_s  = (funct3[1:0] == 2'b01) && funct7_5;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        ctrl_s = 3'b100;
      end
      OPC_LUI: begin
        use_rs1_s = 1'b0;
        opa_s     = '0;
      end
      OPC_AUIPC: begin
        use_rs1_s = 1'b0;
        opa_s     = pc;
      end
      default: begin
        legal_s   = 1'b0;
        use_rs1_s = 1'b0;
      end
    endcase
    we_s = legal_s && (opcode != OPC_STORE) && (rd_addr != 5'd0);
  end

  // Without forwarding, a result-stage producer also blocks issue for one more cycle
  assign dep1_s = tag_hit(rs1_addr, ex_valid, ex_we, ex_rd) ||
                  (!FWD_EN && tag_hit(rs1_addr, res_valid_r, res_we_r, res_rd_r));
  assign dep2_s = tag_hit(rs2_addr, ex_valid, ex_we, ex_rd) ||
                  (!FWD_EN && tag_hit(rs2_addr, res_valid_r, res_we_r, res_rd_r));
  assign hazard_s = in_valid && ((use_rs1_s && dep1_s) || (use_rs2_s && dep2_s));
  assign in_ready = rst_n && !stall && !flush && !hazard_s;
  assign accept_s = in_valid && in_ready;

  // EX registers and result-stage tag; flush overrides stall, illegal never lingers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ALU_ctrl    <= 3'b000;
      Funct3      <= 3'b000;
      Funct7_5    <= 1'b0;
      Sub         <= 1'b0;
      Rs1         <= '0;
      Rs2         <= '0;
      ex_valid    <= 1'b0;
      ex_rd       <= 5'd0;
      ex_we       <= 1'b0;
      illegal     <= 1'b0;
      res_valid_r <= 1'b0;
      res_rd_r    <= 5'd0;
      res_we_r    <= 1'b0;
    end else if (flush || !stall) begin
      res_valid_r <= ex_valid;
      res_rd_r    <= ex_rd;
      res_we_r    <= ex_we;
      if (accept_s && legal_s) begin
        ALU_ctrl <= ctrl_s;
        Funct3   <= funct3;
        Funct7_5 <= f75_s;
        Sub      <= sub_s;
        Rs1      <= opa_s;
        Rs2      <= opb_s;
        ex_valid <= 1'b1;
        ex_rd    <= rd_addr;
        ex_we    <= we_s;
        illegal  <= 1'b0;
      end else begin
        ALU_ctrl <= 3'b000;
        Funct3   <= 3'b000;
        Funct7_5 <= 1'b0;
        Sub      <= 1'b0;
        Rs1      <= '0;
        Rs2      <= '0;
        ex_valid <= 1'b0;
        ex_rd    <= 5'd0;
        ex_we    <= 1'b0;
        illegal  <= accept_s;
      end
    end else begin
      illegal <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 SHALL have input CLK, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input in_valid, 1 bit: the decoded instruction on the in_* fields is valid.
REQ-005 SHALL have output in_ready, 1 bit: the instruction is accepted on this edge.
REQ-006 SHALL have inputs opcode[6:0], funct3[2:0], funct7_5 (1), rs1_addr[4:0], rs2_addr[4:0] and rd_addr[4:0]: the instruction fields.
REQ-007 SHALL have inputs rs1_data, rs2_data, imm and pc, each XLEN bits: the register-file reads, the sign-extended immediate and the instruction address.
REQ-008 SHALL have inputs stall (1: hold the EX registers) and flush (1: kill the EX contents).
REQ-009 SHALL have input Result, XLEN bits: the registered ALU output, fed back for forwarding.
REQ-010 SHALL have registered outputs ALU_ctrl[2:0], Funct3[2:0], Funct7_5, Sub, Rs1[XLEN-1:0] and Rs2[XLEN-1:0]: the ALU operation and operands.
REQ-011 SHALL have registered outputs ex_valid, ex_rd[4:0], ex_we and illegal: the EX-stage tag and the illegal-opcode pulse.

Function
REQ-012 SHALL decode the ALU operation (Funct3 passed through in all cases):
- OP / OP-IMM: funct3 000 -> ALU_ctrl 000; 010/011 -> 001; 100/110/111 -> 010; 001/101 -> 011.
- LOAD, STORE, JALR -> 100.
- LUI, AUIPC -> 000.
REQ-013 SHALL set Sub=1 only for OP with funct3=000 and funct7_5=1; Funct7_5 SHALL be funct7_5 for OP and OP-IMM shifts, else 0.
REQ-014 SHALL select operands:
- OP: Rs1=rs1, Rs2=rs2.
- OP-IMM/LOAD/STORE/JALR: Rs1=rs1, Rs2=imm.
- LUI: Rs1=0, Rs2=imm.
- AUIPC: Rs1=pc, Rs2=imm.
REQ-015 SHALL set ex_we=1 for OP, OP-IMM, LOAD, JALR, LUI and AUIPC with rd_addr!=0, else 0.
REQ-016 SHALL treat any other opcode as illegal: issue a bubble, pulse illegal for one cycle and accept the instruction.
REQ-017 SHALL accept an instruction (in_valid and in_ready) at the edge, loading the EX registers with ex_valid=1 (1-cycle latency to the ALU).
REQ-018 SHALL, on a bubble, load ALU_ctrl=000, Sub=0, Rs1=Rs2=0, ex_valid=0 and ex_we=0.
REQ-019 SHALL keep a result-stage tag (res_valid, res_rd, res_we) equal to the previous edge's EX tag, aligned with Result.
REQ-020 SHALL raise a hazard when a used source register (rs1 for all but LUI/AUIPC; rs2 for OP only) is nonzero and equals ex_rd with ex_valid and ex_we set.
REQ-021 SHALL, on a hazard, drive in_ready=0 and issue a bubble for exactly one cycle.
REQ-022 SHALL substitute Result for a source operand that matches res_rd with res_valid and res_we set (forwarding enabled).
REQ-023 SHALL, with stall=1 and flush=0, hold all EX registers and drive in_ready=0; the result-stage tag SHALL then also hold.
REQ-024 SHALL, with flush=1, load a bubble, drive in_ready=0 and ignore stall; the result-stage tag SHALL still advance.
REQ-025 SHALL give register x0 no hazard and no forwarding.
REQ-026 SHALL otherwise drive in_ready=1 combinationally.

Reset
REQ-027 SHALL, while rst_n=0, immediately clear all EX and result-stage registers to 0 (ex_valid=0, illegal=0, ALU_ctrl=000); in_ready SHALL be 0 during reset.
REQ-028 SHALL discard an instruction held by stall when reset is asserted mid-operation; no replay.

Configuration
REQ-029 SHALL, with macro ALU_ISSUE_FWD_EN defined, implement REQ-022.
REQ-030 SHALL, without ALU_ISSUE_FWD_EN, omit the Result forwarding path and extend the hazard to matches against the result-stage tag (two bubbles per back-to-back dependency).

Verification
REQ-031 SHALL cover: OP SUB x3=x1-x2 with rs1_data=10, rs2_data=3 -> next edge ALU_ctrl=000, Sub=1, Rs1=10, Rs2=3, ex_valid=1, ex_rd=3.
REQ-032 SHALL cover: ADDI x5=x3+1 right after REQ-031 (FWD_EN) -> one bubble with in_ready=0, then Rs1=Result=7, Rs2=1.
REQ-033 SHALL cover: the same sequence without FWD_EN -> two bubbles, then Rs1=rs1_data.
REQ-034 SHALL cover: AUIPC with pc=0x100 and imm=0x2000 -> ALU_ctrl=000, Rs1=0x100, Rs2=0x2000; opcode 0x7F -> illegal=1 for one cycle and ex_valid=0.
REQ-035 SHALL cover: stall=1 for 3 cycles with a valid EX instruction -> outputs unchanged and in_ready=0; flush=1 with stall=1 -> ex_valid=0 next edge.
REQ-036 SHALL cover: rst_n dropped mid-stall -> all outputs 0 immediately, with no dependence on clock.
